chaos_osc_multi: RTL and testbench

- Parametrised successor to the single-mode Lorenz oscillator.
- Integrates either the Lorenz or the Chen 3-D chaotic system with forward Euler in signed fixed point (WIDTH bits, FRAC fractional bits).
- Uses one shared multiplier, time-multiplexed over a fixed 7-cycle iteration.
- Adds run/pause control, iteration limit, valid strobe, reload and saturation flag. Feeds DAC/trace-capture logic downstream.

---
 rtl/chaos_osc_multi.sv | 219 +++++++++++++++++++++
 tb/tb_chaos_osc_multi.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chaos_osc_multi.sv
// Lorenz / Chen chaotic oscillator, forward-Euler integration in signed fixed point.
// One shared multiplier is time-multiplexed over a 7-cycle iteration:
// six CALC cycles (one product each) followed by one UPDATE cycle.
module chaos_osc_multi #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      FRAC    = 21,
  parameter int unsigned      H_SHIFT = 8,
  parameter logic [WIDTH-1:0] X0      = WIDTH'(32'd2097152),
  parameter logic [WIDTH-1:0] Y0      = '0,
  parameter logic [WIDTH-1:0] Z0      = '0,
  parameter logic [WIDTH-1:0] SIGMA   = WIDTH'(32'd20971520),
  parameter logic [WIDTH-1:0] RHO     = WIDTH'(32'd58720256),
  parameter logic [WIDTH-1:0] BETA    = WIDTH'(32'd5592405),
  parameter logic [WIDTH-1:0] CA      = WIDTH'(32'd73400320),
  parameter logic [WIDTH-1:0] CB      = WIDTH'(32'd6291456),
  parameter logic [WIDTH-1:0] CC      = WIDTH'(32'd58720256),
  parameter int unsigned      ITW     = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             mode_i,
  input  logic [ITW-1:0]   iter_max_i,
  output logic [WIDTH-1:0] xn_o,
  output logic [WIDTH-1:0] yn_o,
  output logic [WIDTH-1:0] zn_o,
  output logic             valid_o,
  output logic [ITW-1:0]   iter_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             sat_o
);

  localparam int unsigned PW = 2 * WIDTH + 2;
  localparam logic [WIDTH:0] CcMinusCa = {CC[WIDTH-1], CC} - {CA[WIDTH-1], CA};

  typedef enum logic [1:0] {StIdle, StCalc, StUpdate, StDone} state_e;
  typedef enum logic [1:0] {TgtNone, TgtDx, TgtDy, TgtDz} tgt_e;

  state_e           state_q, state_d;
  logic [2:0]       k_q;
  logic             mode_q;
  logic [WIDTH-1:0] x_q, y_q, z_q;
  logic             valid_q;
  logic [ITW-1:0]   iter_q, iter_inc;
  logic             sat_q;
  logic [WIDTH+3:0] dx_q, dy_q, dz_q;

  logic [WIDTH:0]   op_a, op_b, y_m_x, rho_m_z;
  tgt_e             tgt;
  logic             sub;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] p;
  logic [WIDTH+3:0] p_ext;
  logic [WIDTH:0]   x_upd, y_upd, z_upd;
  logic             any_sat;

  function automatic logic [WIDTH:0] sx1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], v};
  endfunction

  function automatic logic [WIDTH+3:0] sx4(input logic [WIDTH-1:0] v);
    return {{4{v[WIDTH-1]}}, v};
  endfunction

  // Returns {clamped, s + (d >>> H_SHIFT) saturated to WIDTH bits}.
  function automatic logic [WIDTH:0] sat_step(input logic [WIDTH-1:0] s,
                                              input logic [WIDTH+3:0] d);
    logic [WIDTH+3:0] ds;
    logic [WIDTH+4:0] sum;
    logic [WIDTH:0]   r;
    ds  = $signed(d) >>> H_SHIFT;
    sum = {{5{s[WIDTH-1]}}, s} + {ds[WIDTH+3], ds};
    if (sum[WIDTH+4:WIDTH-1] == '0 || sum[WIDTH+4:WIDTH-1] == '1) begin
      r = {1'b0, sum[WIDTH-1:0]};
    end else if (sum[WIDTH+4]) begin
      r = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      r = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

  assign y_m_x    = sx1(y_q) - sx1(x_q);
  assign rho_m_z  = sx1(RHO) - sx1(z_q);
  assign iter_inc = iter_q + ITW'(1);

  // Multiplier schedule: operands and accumulator target for product k.
  always_comb begin
    op_a = '0;
    op_b = '0;
    tgt  = TgtNone;
    sub  = 1'b0;
    if (!mode_q) begin
      case (k_q)
        3'd0: begin op_a = sx1(SIGMA); op_b = y_m_x;    tgt = TgtDx; end
        3'd1: begin op_a = sx1(x_q);   op_b = rho_m_z;  tgt = TgtDy; end
        3'd2: begin op_a = sx1(x_q);   op_b = sx1(y_q); tgt = TgtDz; end
        3'd3: begin op_a = sx1(BETA);  op_b = sx1(z_q); tgt = TgtDz; sub = 1'b1; end
        default: ;
      endcase
    end else begin
      case (k_q)
        3'd0: begin op_a = sx1(CA);   op_b = y_m_x;    tgt = TgtDx; end
        3'd1: begin op_a = CcMinusCa; op_b = sx1(x_q); tgt = TgtDy; end
        3'd2: begin op_a = sx1(x_q);  op_b = sx1(z_q); tgt = TgtDy; sub = 1'b1; end
        3'd3: begin op_a = sx1(CC);   op_b = sx1(y_q); tgt = TgtDy; end
        3'd4: begin op_a = sx1(x_q);  op_b = sx1(y_q); tgt = TgtDz; end
        3'd5: begin op_a = sx1(CB);   op_b = sx1(z_q); tgt = TgtDz; sub = 1'b1; end
        default: ;
      endcase
    end
  end

  // Sign-extended operands: the low PW bits of the unsigned product equal the signed product.
  assign prod  = {{(WIDTH+1){op_a[WIDTH]}}, op_a} * {{(WIDTH+1){op_b[WIDTH]}}, op_b};
  assign p     = WIDTH'(prod >> FRAC);
  assign p_ext = sx4(p);

  assign x_upd   = sat_step(x_q, dx_q);
  assign y_upd   = sat_step(y_q, dy_q);
  assign z_upd   = sat_step(z_q, dz_q);
  assign any_sat = x_upd[WIDTH] | y_upd[WIDTH] | z_upd[WIDTH];

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (!clear_i && start_i) state_d = StCalc;
      StCalc:   if (k_q == 3'd5) state_d = StUpdate;
      StUpdate: begin
        if (iter_max_i != '0 && iter_inc == iter_max_i) state_d = StDone;
        else if (start_i)                               state_d = StCalc;
        else                                            state_d = StIdle;
      end
      StDone:   if (clear_i || !start_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM status outputs.
  always_comb begin
    busy_o = (state_q == StCalc) || (state_q == StUpdate);
    done_o = (state_q == StDone);
  end

  // Datapath: product accumulation, state update, counters and flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q     <= X0;
      y_q     <= Y0;
      z_q     <= Z0;
      valid_q <= 1'b0;
      iter_q  <= '0;
      sat_q   <= 1'b0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      dz_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          k_q <= '0;
          if (clear_i) begin
            x_q    <= X0;
            y_q    <= Y0;
            z_q    <= Z0;
            iter_q <= '0;
            sat_q  <= 1'b0;
          end else if (start_i && state_q == StIdle) begin
            mode_q <= mode_i;
          end
        end
        StCalc: begin
          k_q <= k_q + 3'd1;
          if (k_q == 3'd0) begin
            // First product always feeds dx; Lorenz dy starts from -y.
            dx_q <= p_ext;
            dy_q <= mode_q ? '0 : -sx4(y_q);
            dz_q <= '0;
          end else begin
            case (tgt)
              TgtDy:   dy_q <= sub ? dy_q - p_ext : dy_q + p_ext;
              TgtDz:   dz_q <= sub ? dz_q - p_ext : dz_q + p_ext;
              default: ;
            endcase
          end
        end
        StUpdate: begin
          k_q     <= '0;
          x_q     <= x_upd[WIDTH-1:0];
          y_q     <= y_upd[WIDTH-1:0];
          z_q     <= z_upd[WIDTH-1:0];
          valid_q <= 1'b1;
          iter_q  <= iter_inc;
          sat_q   <= sat_q | any_sat;
        end
        default: ;
      endcase
    end
  end

  assign xn_o    = x_q;
  assign yn_o    = y_q;
  assign zn_o    = z_q;
  assign valid_o = valid_q;
  assign iter_o  = iter_q;
  assign sat_o   = sat_q;

endmodule

// File: tb/tb_chaos_osc_multi.sv
// Self-checking bench for chaos_osc_multi: directed sequence plus randomized runs
// checked against a formula-level model of the Lorenz / Chen Euler step.
module tb_chaos_osc_multi;

  localparam longint SIGMA = 20971520;
  localparam longint RHO   = 58720256;
  localparam longint BETA  = 5592405;
  localparam longint CA    = 73400320;
  localparam longint CB    = 6291456;
  localparam longint CC    = 58720256;
  localparam longint X0    = 2097152;
  localparam longint X0S   = 2146435072;
  localparam longint SMAX  = 64'sd2147483647;
  localparam longint SMIN  = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default parameters).
  logic        rst_n, start, clear, mode;
  logic [31:0] iter_max;
  logic [31:0] xn, yn, zn, iter;
  logic        valid, busy, done, sat;

  // Saturation DUT (large X0, h = 1).
  logic        s_rst_n, s_start, s_clear, s_mode;
  logic [31:0] s_iter_max;
  logic [31:0] s_xn, s_yn, s_zn, s_iter;
  logic        s_valid, s_busy, s_done, s_sat;

  chaos_osc_multi dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear), .mode_i(mode),
    .iter_max_i(iter_max), .xn_o(xn), .yn_o(yn), .zn_o(zn), .valid_o(valid),
    .iter_o(iter), .busy_o(busy), .done_o(done), .sat_o(sat)
  );

  chaos_osc_multi #(.X0(32'h7FF0_0000), .H_SHIFT(0)) dut_s (
    .clk_i(clk), .rst_ni(s_rst_n), .start_i(s_start), .clear_i(s_clear), .mode_i(s_mode),
    .iter_max_i(s_iter_max), .xn_o(s_xn), .yn_o(s_yn), .zn_o(s_zn), .valid_o(s_valid),
    .iter_o(s_iter), .busy_o(s_busy), .done_o(s_done), .sat_o(s_sat)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  longint      mx, my, mz, sx, sy, sz;
  int unsigned miter;
  bit          msat, ssat;
  logic [31:0] cap_x, cap_y, cap_z, cap_iter;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] w32(input longint v);
    return {32'b0, v[31:0]};
  endfunction

  // Q11.21 product: floor((a*b) / 2^21), wrapped to 32-bit two's complement.
  function automatic longint mulq(input longint a, input longint b);
    longint pr;
    pr = (a * b) >>> 21;
    return longint'(int'(pr));
  endfunction

  function automatic longint clampw(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  // One Euler step of the selected system from (x, y, z).
  task automatic mstep(input bit md, input int hs, inout longint x, inout longint y,
                       inout longint z, inout bit s);
    longint dx, dy, dz, nx, ny, nz;
    if (!md) begin
      dx = mulq(SIGMA, y - x);
      dy = mulq(x, RHO - z) - y;
      dz = mulq(x, y) - mulq(BETA, z);
    end else begin
      dx = mulq(CA, y - x);
      dy = mulq(CC - CA, x) - mulq(x, z) + mulq(CC, y);
      dz = mulq(x, y) - mulq(CB, z);
    end
    nx = x + (dx >>> hs);
    ny = y + (dy >>> hs);
    nz = z + (dz >>> hs);
    if (clampw(nx) != nx || clampw(ny) != ny || clampw(nz) != nz) s = 1'b1;
    x = clampw(nx);
    y = clampw(ny);
    z = clampw(nz);
  endtask

  task automatic model_reset();
    mx = X0; my = 0; mz = 0; miter = 0; msat = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_x"}, xn, w32(mx));
    chk({tag, "_y"}, yn, w32(my));
    chk({tag, "_z"}, zn, w32(mz));
    chk({tag, "_iter"}, iter, 64'(miter));
    chk({tag, "_sat"}, sat, 64'(msat));
  endtask

  // Run n iterations of mode md; start is dropped inside the last iteration's CALC.
  // mode_i and clear_i are scrambled while the DUT is busy and must have no effect.
  task automatic run(input int n, input bit md);
    int ticks;
    bit got;
    mode  = md;
    start = 1'b1;
    tick();
    if (n == 1) start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      got   = 1'b0;
      ticks = 0;
      for (int t = 0; t < 16 && !got; t++) begin
        tick();
        ticks++;
        if (ticks == 1) chk("busy_calc", busy, 1);
        if (valid) got = 1'b1;
        else begin
          mode  = 1'($urandom);
          clear = 1'($urandom);
        end
      end
      clear = 1'b0;
      chk("valid_seen", got, 1);
      chk("period", ticks, 7);
      mstep(md, 8, mx, my, mz, msat);
      miter++;
      chk_state("run");
      if (c == 1) begin
        cap_x = xn; cap_y = yn; cap_z = zn; cap_iter = iter;
      end
      if (c == n - 1) start = 1'b0;
    end
    chk("busy_idle", busy, 0);
  endtask

  task automatic s_wait(output bit got);
    got = 1'b0;
    for (int t = 0; t < 16 && !got; t++) begin
      tick();
      if (s_valid) got = 1'b1;
    end
  endtask

  initial begin
    int vcount;
    bit bseen, got;

    rst_n = 1'b0; start = 1'b0; clear = 1'b0; mode = 1'b0; iter_max = '0;
    s_rst_n = 1'b0; s_start = 1'b0; s_clear = 1'b0; s_mode = 1'b0; s_iter_max = '0;
    model_reset();

    // 1. Reset and idle.
    tick(); tick();
    chk_state("in_reset");
    chk("in_reset_valid", valid, 0);
    rst_n = 1'b1;
    vcount = 0;
    bseen  = 1'b0;
    repeat (20) begin
      tick();
      vcount += int'(valid);
      bseen |= busy;
    end
    chk("idle_valid", vcount, 0);
    chk("idle_busy", bseen, 0);
    chk("idle_done", done, 0);
    chk_state("idle");

    // 2 + 5. Lorenz, start held; pause inside iteration 3, then resume.
    run(3, 1'b0);
    chk("lor1_x", cap_x, 32'h001E_C000);
    chk("lor1_y", cap_y, 32'h0003_8000);
    chk("lor1_z", cap_z, 32'h0000_0000);
    chk("lor1_iter", cap_iter, 1);
    vcount = 0;
    repeat (5) begin
      tick();
      vcount += int'(valid);
    end
    chk("pause_valid", vcount, 0);
    chk_state("paused");
    run(1, 1'b0);
    chk("iter4", iter, 4);

    // 3. Chen single iteration from the initial state.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    chk_state("clear");
    run(1, 1'b1);
    chk("chen1_x", cap_x, 32'h001B_A000);
    chk("chen1_y", cap_y, 32'hFFFF_2000);
    chk("chen1_z", cap_z, 32'h0000_0000);

    // Randomized run lengths and modes continuing the trajectory.
    for (int r = 0; r < 4; r++) run(1 + int'($urandom % 3), 1'($urandom));

    // 4. Iteration limit.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    iter_max = 32'd5;
    mode     = 1'b0;
    start    = 1'b1;
    vcount   = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      tick();
      if (valid) begin
        vcount++;
        mstep(1'b0, 8, mx, my, mz, msat);
        miter++;
        chk_state("lim");
      end
    end
    chk("lim_done", done, 1);
    chk("lim_pulses", vcount, 5);
    chk("lim_iter", iter, 5);
    vcount = 0;
    bseen  = 1'b1;
    repeat (3) begin
      tick();
      vcount += int'(valid);
      bseen &= done;
    end
    chk("done_hold_valid", vcount, 0);
    chk("done_hold", bseen, 1);
    start = 1'b0;
    tick();
    chk("done_exit", done, 0);
    chk("done_exit_busy", busy, 0);
    chk_state("done_idle");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    chk_state("clear2");
    iter_max = '0;

    // 6. Saturation, stickiness, clear, and reset mid-CALC.
    s_rst_n = 1'b1;
    tick();
    s_start = 1'b1;
    tick();
    s_wait(got);
    chk("s_valid1", got, 1);
    sx = X0S; sy = 0; sz = 0; ssat = 1'b0;
    mstep(1'b0, 0, sx, sy, sz, ssat);
    chk("s1_x", s_xn, w32(sx));
    chk("s1_y", s_yn, w32(sy));
    chk("s1_z", s_zn, w32(sz));
    chk("s1_sat", s_sat, 64'(ssat));
    chk("s1_clamp", s_xn, 32'h7FFF_FFFF);
    s_start = 1'b0;
    s_wait(got);
    chk("s_valid2", got, 1);
    mstep(1'b0, 0, sx, sy, sz, ssat);
    chk("s2_x", s_xn, w32(sx));
    chk("s2_y", s_yn, w32(sy));
    chk("s2_z", s_zn, w32(sz));
    chk("s2_iter", s_iter, 2);
    repeat (3) tick();
    chk("s_sticky", s_sat, 1);
    chk("s_paused", s_busy, 0);
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    chk("s_clr_sat", s_sat, 0);
    chk("s_clr_x", s_xn, w32(X0S));
    chk("s_clr_iter", s_iter, 0);
    s_start = 1'b1;
    tick();
    s_wait(got);
    chk("s_valid3", got, 1);
    tick();
    tick();
    chk("s_midcalc_busy", s_busy, 1);
    chk("s_midcalc_sat", s_sat, 1);
    #2;
    s_rst_n = 1'b0;
    #1;
    chk("s_rst_x", s_xn, w32(X0S));
    chk("s_rst_y", s_yn, 0);
    chk("s_rst_z", s_zn, 0);
    chk("s_rst_iter", s_iter, 0);
    chk("s_rst_sat", s_sat, 0);
    chk("s_rst_busy", s_busy, 0);
    chk("s_rst_valid", s_valid, 0);
    chk("s_rst_done", s_done, 0);
    s_start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
